// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the ALU issue queue: ALU command and operand
// encodings, queue geometry and the stored entry layout.
package issue_queue_pkg;

  localparam int ISQ_DEPTH            = 8;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int ISQ_IDX_WIDTH        = $clog2(ISQ_DEPTH);
  localparam int ISQ_CNT_WIDTH        = $clog2(ISQ_DEPTH + 1);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_t;

  typedef enum logic {
    OP_REG = 1'b0,
    OP_IMM = 1'b1
  } op_type_t;

  typedef struct packed {
    alu_cmd_t                        cmd;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] op1;
    logic                            op1_rdy;
    op_type_t                        op2_type;
    logic [31:0]                     op2;
    logic                            op2_rdy;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
  } isq_entry_t;

  // An immediate second operand never waits on a wakeup.
  function automatic logic entry_ready(input isq_entry_t e);
    return e.op1_rdy && (e.op2_rdy || (e.op2_type == OP_IMM));
  endfunction

endpackage

// File: rtl/isq_issue_if.sv
// Issue bundle from the issue queue to the ALU executers, one lane per
// dispatch slot; the executer side always accepts.
interface isqIssueIf;
  import issue_queue_pkg::*;

  logic [DISPATCH_WIDTH-1:0]       valid;
  alu_cmd_t                        alu_cmd [DISPATCH_WIDTH];
  logic [PHYS_REGS_ADDR_WIDTH-1:0] op1     [DISPATCH_WIDTH];
  op_type_t                        op2_type[DISPATCH_WIDTH];
  logic [31:0]                     op2     [DISPATCH_WIDTH];
  logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd [DISPATCH_WIDTH];

  modport out (output valid, alu_cmd, op1, op2_type, op2, phys_rd);
  modport in  (input  valid, alu_cmd, op1, op2_type, op2, phys_rd);
endinterface

// File: rtl/isq_select.sv
// Oldest-first pick of up to DISPATCH_WIDTH ready entries. Entry 0 is the
// oldest; lane k carries the k-th ready entry found scanning upward.
module isq_select
  import issue_queue_pkg::*;
(
  input  isq_entry_t [ISQ_DEPTH-1:0]  entries,
  input  logic [ISQ_DEPTH-1:0]        entry_valid,
  output logic [ISQ_IDX_WIDTH-1:0]    lane_idx [DISPATCH_WIDTH],
  output logic [DISPATCH_WIDTH-1:0]   lane_valid,
  output logic [ISQ_DEPTH-1:0]        issued
);

  int                   rank [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0] cand;

  // Rank each ready entry by how many ready entries are older than it.
  always_comb begin
    int seen;
    seen   = 0;
    cand   = '0;
    issued = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      rank[i]   = seen;
      cand[i]   = entry_valid[i] && entry_ready(entries[i]);
      if (cand[i]) seen = seen + 1;
      issued[i] = cand[i] && (rank[i] < DISPATCH_WIDTH);
    end
  end

  always_comb begin
    lane_valid = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      lane_idx[k] = '0;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        if (issued[i] && (rank[i] == k)) begin
          lane_idx[k]   = i[ISQ_IDX_WIDTH-1:0];
          lane_valid[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered, compacting ALU issue queue: all-or-nothing dispatch, wakeup
// from writeback, oldest-ready select and compaction of the survivors.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [DISPATCH_WIDTH-1:0]       disp_valid,
  input  alu_cmd_t                        disp_alu_cmd  [DISPATCH_WIDTH],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] disp_op1      [DISPATCH_WIDTH],
  input  logic [DISPATCH_WIDTH-1:0]       disp_op1_rdy,
  input  op_type_t                        disp_op2_type [DISPATCH_WIDTH],
  input  logic [31:0]                     disp_op2      [DISPATCH_WIDTH],
  input  logic [DISPATCH_WIDTH-1:0]       disp_op2_rdy,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] disp_phys_rd  [DISPATCH_WIDTH],
  output logic                            disp_ready,
  input  logic [DISPATCH_WIDTH-1:0]       wb_valid,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd    [DISPATCH_WIDTH],
  isqIssueIf.out                          issue
);

  localparam int PRA = PHYS_REGS_ADDR_WIDTH;

  isq_entry_t [ISQ_DEPTH-1:0] entries;
  isq_entry_t [ISQ_DEPTH-1:0] entries_next;
  logic [ISQ_CNT_WIDTH-1:0]   count;
  logic [ISQ_CNT_WIDTH-1:0]   count_next;
  logic [ISQ_DEPTH-1:0]       entry_valid;
  logic [ISQ_DEPTH-1:0]       issued;
  logic [ISQ_IDX_WIDTH-1:0]   lane_idx [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0]  lane_valid;
  isq_entry_t                 disp_entry [DISPATCH_WIDTH];
  int                         surv_pos [ISQ_DEPTH];
  int                         disp_pos [DISPATCH_WIDTH];

  for (genvar i = 0; i < ISQ_DEPTH; i++) begin : g_valid
    assign entry_valid[i] = ISQ_CNT_WIDTH'(i) < count;
  end

  // Slots freed by this cycle's issue are deliberately not counted.
  assign disp_ready = (ISQ_DEPTH - int'(count)) >= DISPATCH_WIDTH;

  isq_select u_select (
    .entries     (entries),
    .entry_valid (entry_valid),
    .lane_idx    (lane_idx),
    .lane_valid  (lane_valid),
    .issued      (issued)
  );

  always_comb begin
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      disp_entry[l].cmd      = disp_alu_cmd[l];
      disp_entry[l].op1      = disp_op1[l];
      disp_entry[l].op1_rdy  = disp_op1_rdy[l];
      disp_entry[l].op2_type = disp_op2_type[l];
      disp_entry[l].op2      = disp_op2[l];
      disp_entry[l].op2_rdy  = disp_op2_rdy[l];
      disp_entry[l].phys_rd  = disp_phys_rd[l];
    end
  end

  // Survivors move down past issued entries; valid dispatch lanes pack on top.
  always_comb begin
    int kept;
    int added;
    kept  = 0;
    added = 0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      surv_pos[i] = kept;
      if (entry_valid[i] && !issued[i]) kept = kept + 1;
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      disp_pos[l] = kept + added;
      if (disp_valid[l]) added = added + 1;
    end
    count_next = ISQ_CNT_WIDTH'(kept + added);
  end

  for (genvar j = 0; j < ISQ_DEPTH; j++) begin : g_slot
    isq_entry_t e;

    // Wakeup is applied after the move so freshly dispatched ops see it too.
    always_comb begin
      e = entries[j];
      for (int i = 0; i < ISQ_DEPTH; i++)
        if (entry_valid[i] && !issued[i] && (surv_pos[i] == j)) e = entries[i];
      for (int l = 0; l < DISPATCH_WIDTH; l++)
        if (disp_valid[l] && (disp_pos[l] == j)) e = disp_entry[l];
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (wb_valid[l]) begin
          if (e.op1 == wb_phys_rd[l]) e.op1_rdy = 1'b1;
          if ((e.op2_type == OP_REG) && (e.op2[PRA-1:0] == wb_phys_rd[l])) e.op2_rdy = 1'b1;
        end
      end
    end

    assign entries_next[j] = e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      entries <= '0;
    end else if (flush) begin
      count   <= '0;
    end else begin
      count   <= count_next;
      entries <= entries_next;
    end
  end

  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      issue.valid[k]    = lane_valid[k] && !flush;
      issue.alu_cmd[k]  = entries[lane_idx[k]].cmd;
      issue.op1[k]      = entries[lane_idx[k]].op1;
      issue.op2_type[k] = entries[lane_idx[k]].op2_type;
      issue.op2[k]      = entries[lane_idx[k]].op2;
      issue.phys_rd[k]  = entries[lane_idx[k]].phys_rd;
    end
  end

  no_dispatch_when_not_ready: assert property (
    @(posedge clk) disable iff (rst) !((|disp_valid) && !disp_ready));

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DW = DISPATCH_WIDTH;

  typedef struct packed {
    alu_cmd_t    cmd;
    logic [5:0]  op1;
    logic        op1_rdy;
    op_type_t    op2_type;
    logic [31:0] op2;
    logic        op2_rdy;
    logic [5:0]  rd;
  } op_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [DW-1:0]     disp_valid;
  alu_cmd_t          disp_alu_cmd  [DW];
  logic [5:0]        disp_op1      [DW];
  logic [DW-1:0]     disp_op1_rdy;
  op_type_t          disp_op2_type [DW];
  logic [31:0]       disp_op2      [DW];
  logic [DW-1:0]     disp_op2_rdy;
  logic [5:0]        disp_phys_rd  [DW];
  logic              disp_ready;
  logic [DW-1:0]     wb_valid;
  logic [5:0]        wb_phys_rd    [DW];

  isqIssueIf issue_if ();

  issue_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_alu_cmd  (disp_alu_cmd),
    .disp_op1      (disp_op1),
    .disp_op1_rdy  (disp_op1_rdy),
    .disp_op2_type (disp_op2_type),
    .disp_op2      (disp_op2),
    .disp_op2_rdy  (disp_op2_rdy),
    .disp_phys_rd  (disp_phys_rd),
    .disp_ready    (disp_ready),
    .wb_valid      (wb_valid),
    .wb_phys_rd    (wb_phys_rd),
    .issue         (issue_if)
  );

  always #5 clk = ~clk;

  int         n_vectors = 0;
  int         n_miscompares = 0;
  op_t        mq[$];
  op_t        cur_ops [DW];
  logic [DW-1:0] cur_dv;
  logic [DW-1:0] cur_wbv;
  logic [5:0] cur_wb [DW];
  logic       cur_flush;
  op_t        nop;

  function automatic op_t mk_op(alu_cmd_t c, logic [5:0] s1, logic r1, op_type_t t,
                                logic [31:0] s2, logic r2, logic [5:0] rd);
    op_t o;
    o.cmd = c; o.op1 = s1; o.op1_rdy = r1; o.op2_type = t;
    o.op2 = s2; o.op2_rdy = r2; o.rd = rd;
    return o;
  endfunction

  function automatic logic op_ready(op_t o);
    return o.op1_rdy && (o.op2_type == OP_IMM || o.op2_rdy);
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [31:0] t;
    o.cmd      = alu_cmd_t'(4'($urandom_range(0, 9)));
    o.op1      = 6'($urandom_range(0, 15));
    o.op1_rdy  = ($urandom_range(0, 2) != 0);
    o.op2_type = ($urandom_range(0, 3) == 0) ? OP_IMM : OP_REG;
    t = $urandom;
    if (o.op2_type == OP_REG) t[5:0] = 6'($urandom_range(0, 15));
    o.op2      = t;
    o.op2_rdy  = ($urandom_range(0, 2) != 0);
    o.rd       = 6'($urandom_range(0, 63));
    return o;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic [DW-1:0] dv, op_t a, op_t b, logic [DW-1:0] wv,
                               logic [5:0] w0, logic [5:0] w1, logic fl);
    cur_ops[0] = a; cur_ops[1] = b;
    cur_dv = dv; cur_wbv = wv; cur_wb[0] = w0; cur_wb[1] = w1; cur_flush = fl;
    for (int l = 0; l < DW; l++) begin
      disp_valid[l]    = dv[l];
      disp_alu_cmd[l]  = cur_ops[l].cmd;
      disp_op1[l]      = cur_ops[l].op1;
      disp_op1_rdy[l]  = cur_ops[l].op1_rdy;
      disp_op2_type[l] = cur_ops[l].op2_type;
      disp_op2[l]      = cur_ops[l].op2;
      disp_op2_rdy[l]  = cur_ops[l].op2_rdy;
      disp_phys_rd[l]  = cur_ops[l].rd;
      wb_phys_rd[l]    = cur_wb[l];
    end
    wb_valid = wv;
    flush    = fl;
  endtask

  task automatic idle();
    applyStimulus('0, nop, nop, '0, 6'd0, 6'd0, 1'b0);
  endtask

  // Expected outputs: first DW ready ops in age order, none during a flush.
  task automatic checkOutput();
    int sel[$];
    if (!cur_flush)
      foreach (mq[i]) if (sel.size() < DW && op_ready(mq[i])) sel.push_back(i);
    cmp("disp_ready", disp_ready, (ISQ_DEPTH - mq.size()) >= DW);
    cmp("count", dut.count, mq.size());
    for (int k = 0; k < DW; k++) begin
      cmp($sformatf("lane%0d.valid", k), issue_if.valid[k], k < sel.size());
      if (k < sel.size()) begin
        op_t e;
        e = mq[sel[k]];
        cmp($sformatf("lane%0d.cmd", k), issue_if.alu_cmd[k], e.cmd);
        cmp($sformatf("lane%0d.op1", k), issue_if.op1[k], e.op1);
        cmp($sformatf("lane%0d.op2_type", k), issue_if.op2_type[k], e.op2_type);
        cmp($sformatf("lane%0d.op2", k), issue_if.op2[k], e.op2);
        cmp($sformatf("lane%0d.phys_rd", k), issue_if.phys_rd[k], e.rd);
      end
    end
  endtask

  task automatic update_model();
    op_t nq[$];
    int  nsel;
    nsel = 0;
    if (rst || cur_flush) begin
      mq.delete();
      return;
    end
    foreach (mq[i]) begin
      if (nsel < DW && op_ready(mq[i])) nsel++;
      else nq.push_back(mq[i]);
    end
    for (int l = 0; l < DW; l++) if (cur_dv[l]) nq.push_back(cur_ops[l]);
    foreach (nq[i]) begin
      op_t t;
      t = nq[i];
      for (int l = 0; l < DW; l++) begin
        if (cur_wbv[l]) begin
          if (t.op1 == cur_wb[l]) t.op1_rdy = 1'b1;
          if (t.op2_type == OP_REG && t.op2[5:0] == cur_wb[l]) t.op2_rdy = 1'b1;
        end
      end
      nq[i] = t;
    end
    mq = nq;
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    int blk_src [8] = '{40, 41, 3, 42, 43, 3, 44, 45};
    nop = mk_op(ALU_ADD, 6'd0, 1'b0, OP_REG, 32'd0, 1'b0, 6'd0);
    rst = 1'b1;
    idle();
    #3;
    cmp("reset.valid", issue_if.valid, 2'b00);
    cmp("reset.disp_ready", disp_ready, 1'b1);
    cmp("reset.count", dut.count, 0);
    step();
    step();
    rst = 1'b0;

    // Two ready ops issue together on the following cycle.
    applyStimulus(2'b11, mk_op(ALU_ADD, 6'd1, 1'b1, OP_REG, 32'd2, 1'b1, 6'd10),
                  mk_op(ALU_SUB, 6'd3, 1'b1, OP_REG, 32'd4, 1'b1, 6'd11), '0, 6'd0, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t1.valid", issue_if.valid, 2'b11);
    cmp("t1.rd0", issue_if.phys_rd[0], 6'd10);
    cmp("t1.rd1", issue_if.phys_rd[1], 6'd11);
    step();
    cmp("t1.count", dut.count, 0);

    // Blocked op A waits; younger ready B bypasses it; A wakes one cycle later.
    applyStimulus(2'b11, mk_op(ALU_XOR, 6'd5, 1'b0, OP_REG, 32'd6, 1'b1, 6'd20),
                  mk_op(ALU_OR, 6'd1, 1'b1, OP_IMM, 32'd9, 1'b0, 6'd21), '0, 6'd0, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t2.b_valid", issue_if.valid, 2'b01);
    cmp("t2.b_rd", issue_if.phys_rd[0], 6'd21);
    step();
    applyStimulus('0, nop, nop, 2'b01, 6'd5, 6'd0, 1'b0); #1;
    cmp("t2.no_same_edge", issue_if.valid, 2'b00);
    step();
    idle(); #1;
    cmp("t2.a_valid", issue_if.valid, 2'b01);
    cmp("t2.a_rd", issue_if.phys_rd[0], 6'd20);
    step();

    // Wakeup in the dispatch cycle is caught by the bypass.
    applyStimulus(2'b01, mk_op(ALU_AND, 6'd7, 1'b0, OP_REG, 32'd8, 1'b1, 6'd30), nop,
                  2'b01, 6'd7, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t3.valid", issue_if.valid, 2'b01);
    cmp("t3.rd", issue_if.phys_rd[0], 6'd30);
    step();

    // Immediate operand is ready regardless of op2_rdy and passes through.
    applyStimulus(2'b01, mk_op(ALU_OR, 6'd9, 1'b1, OP_IMM, 32'h0000_0003, 1'b0, 6'd12), nop,
                  '0, 6'd0, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t5.valid", issue_if.valid, 2'b01);
    cmp("t5.op2", issue_if.op2[0], 32'h0000_0003);
    step();

    // Fill with blocked ops; entries 2 and 5 depend on p3.
    for (int g = 0; g < 4; g++) begin
      applyStimulus(2'b11,
        mk_op(ALU_ADD, 6'(blk_src[2*g]), 1'b0, OP_IMM, 32'd0, 1'b0, 6'(50 + 2*g)),
        mk_op(ALU_ADD, 6'(blk_src[2*g+1]), 1'b0, OP_IMM, 32'd0, 1'b0, 6'(51 + 2*g)),
        '0, 6'd0, 6'd0, 1'b0);
      step();
    end
    idle(); #1;
    cmp("t4.full_count", dut.count, 8);
    cmp("t4.full_ready", disp_ready, 1'b0);
    applyStimulus('0, nop, nop, 2'b01, 6'd3, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t4.valid", issue_if.valid, 2'b11);
    cmp("t4.lane0_rd", issue_if.phys_rd[0], 6'd52);
    cmp("t4.lane1_rd", issue_if.phys_rd[1], 6'd55);
    step();
    cmp("t4.count6", dut.count, 6);
    applyStimulus(2'b01, mk_op(ALU_SLT, 6'd46, 1'b0, OP_IMM, 32'd0, 1'b0, 6'd58), nop,
                  '0, 6'd0, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("t4.count7", dut.count, 7);
    cmp("t4.ready7", disp_ready, 1'b0);
    applyStimulus('0, nop, nop, 2'b11, 6'd40, 6'd41, 1'b0);
    step();
    applyStimulus('0, nop, nop, 2'b01, 6'd42, 6'd0, 1'b0); #1;
    cmp("t4.wake_rd0", issue_if.phys_rd[0], 6'd50);
    cmp("t4.wake_rd1", issue_if.phys_rd[1], 6'd51);
    step();

    // Flush with a ready entry and a concurrent dispatch group.
    applyStimulus(2'b11, mk_op(ALU_ADD, 6'd1, 1'b1, OP_IMM, 32'd1, 1'b1, 6'd60),
                  mk_op(ALU_ADD, 6'd1, 1'b1, OP_IMM, 32'd1, 1'b1, 6'd61), '0, 6'd0, 6'd0, 1'b1);
    #1;
    cmp("t6.count5", dut.count, 5);
    cmp("t6.flush_valid", issue_if.valid, 2'b00);
    step();
    idle(); #1;
    cmp("t6.count0", dut.count, 0);
    cmp("t6.ready", disp_ready, 1'b1);
    step();

    // Asynchronous reset while the queue holds an issuable op.
    applyStimulus(2'b11, mk_op(ALU_ADD, 6'd60, 1'b0, OP_IMM, 32'd0, 1'b0, 6'd14),
                  mk_op(ALU_ADD, 6'd61, 1'b0, OP_IMM, 32'd0, 1'b0, 6'd15), '0, 6'd0, 6'd0, 1'b0);
    step();
    applyStimulus(2'b01, mk_op(ALU_SUB, 6'd1, 1'b1, OP_IMM, 32'd5, 1'b0, 6'd13), nop,
                  '0, 6'd0, 6'd0, 1'b0);
    step();
    idle(); #1;
    cmp("rst_mid.pre_valid", issue_if.valid, 2'b01);
    cmp("rst_mid.pre_rd", issue_if.phys_rd[0], 6'd13);
    #1;
    rst = 1'b1;
    mq.delete();
    #1;
    cmp("rst_mid.valid", issue_if.valid, 2'b00);
    cmp("rst_mid.count", dut.count, 0);
    cmp("rst_mid.ready", disp_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    for (int c = 0; c < 800; c++) begin
      logic [DW-1:0] dv;
      logic [DW-1:0] wv;
      logic          fl;
      op_t           a;
      op_t           b;
      a  = rand_op();
      b  = rand_op();
      dv = (mq.size() <= ISQ_DEPTH - DW) ? 2'($urandom_range(0, 3)) : 2'b00;
      wv = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 39) == 0);
      applyStimulus(dv, a, b, wv, 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), fl);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
